// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive stream controller.
// State encoding, default entry geometry and the saturating-counter step test.
package rx_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } rx_state_t;

    localparam int RX_DATA_WIDTH  = 8;
    localparam int RX_ENTRY_WIDTH = RX_DATA_WIDTH + 1;

    // True when a counter should advance: an event occurred and it is not pinned at all-ones.
    function automatic logic sat_step(input logic inc, input logic at_max);
        return inc & ~at_max;
    endfunction

endpackage

// File: rtl/rx_stream_ctrl_fifo.sv
// First-word fall-through FIFO holding {err, data} receive entries.
// Head entry is read combinationally from storage; occupancy is a registered level.
module rx_fifo
    import rx_ctrl_pkg::*;
#(
    parameter int WIDTH = RX_ENTRY_WIDTH,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage carries no reset; an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/rx_stream_ctrl.sv
// Buffers received UART frames into a valid/ready byte stream with overrun/error policy
// and saturating statistics. Optional idle timeout built only when RX_TIMEOUT_EN is defined.
module rx_stream_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = RX_DATA_WIDTH,
    parameter int FIFO_DEPTH       = 8,
    parameter int CNT_WIDTH        = 16,
    parameter int TIMEOUT_CYCLES   = 4096,
    localparam int LW              = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INPUT_DATA_WIDTH-1:0] rx_data,
    input  logic                        rx_valid,
    input  logic                        rx_error,
    input  logic                        halt_on_error,
    input  logic                        drop_errored,
    input  logic                        clear,
    output logic [INPUT_DATA_WIDTH-1:0] m_data,
    output logic                        m_err,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        overrun,
    output logic                        halted,
    output logic [LW-1:0]               level,
    output logic [CNT_WIDTH-1:0]        frame_count,
    output logic [CNT_WIDTH-1:0]        error_count,
    output logic [CNT_WIDTH-1:0]        drop_count,
    output logic                        rx_timeout
);

    localparam int EW = INPUT_DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    rx_state_t   state;
    logic [EW-1:0] head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        eff_run;
    logic        eligible;
    logic        full_reject;
    logic        err_frame;

    // A clear in the same cycle as a frame lets that frame be judged as if already in RUN.
    assign eff_run     = (state == ST_RUN) | clear;
    assign pop         = m_valid & m_ready;
    assign eligible    = rx_valid & eff_run & ~(rx_error & drop_errored);
    assign push        = eligible & (~fifo_full | pop);
    assign full_reject = eligible & fifo_full & ~pop;
    assign err_frame   = rx_valid & rx_error;

    rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({rx_error, rx_data}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign m_valid         = ~fifo_empty;
    assign {m_err, m_data} = m_valid ? head : '0;
    assign halted          = (state == ST_DISCARD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            overrun     <= 1'b0;
            frame_count <= '0;
            error_count <= '0;
            drop_count  <= '0;
        end else begin
            if (rx_valid && eff_run && (full_reject || (rx_error && halt_on_error))) begin
                state <= ST_DISCARD;
            end else if (clear) begin
                state <= ST_RUN;
            end

            overrun <= (overrun & ~clear) | full_reject;

            if (clear)                                 frame_count <= push ? CNT_ONE : '0;
            else if (sat_step(push, &frame_count))     frame_count <= frame_count + CNT_ONE;

            if (clear)                                 error_count <= err_frame ? CNT_ONE : '0;
            else if (sat_step(err_frame, &error_count)) error_count <= error_count + CNT_ONE;

            if (clear)                                 drop_count <= (rx_valid & ~push) ? CNT_ONE : '0;
            else if (sat_step(rx_valid & ~push, &drop_count)) drop_count <= drop_count + CNT_ONE;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || push || pop || clear) begin
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else if (m_valid && idle_cnt != TW'(TIMEOUT_CYCLES)) begin
            idle_cnt   <= idle_cnt + TW'(1);
            rx_timeout <= (idle_cnt + TW'(1) == TW'(TIMEOUT_CYCLES));
        end
    end
`else
    // Constant 0; the expression only keeps the unused parameter referenced.
    assign rx_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_rx_stream_ctrl.sv
// Testbench for rx_stream_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_rx_stream_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int TO    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_error, halt_on_error, drop_errored, clear, m_ready;
  logic [DW-1:0] m_data;
  logic          m_err, m_valid, overrun, halted, rx_timeout;
  logic [3:0]    level;
  logic [CW-1:0] frame_count, error_count, drop_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // clock / reset
  always #5 clk = ~clk;

  rx_stream_ctrl #(
    .INPUT_DATA_WIDTH (DW),
    .FIFO_DEPTH       (DEPTH),
    .CNT_WIDTH        (CW),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .halt_on_error (halt_on_error),
    .drop_errored  (drop_errored),
    .clear         (clear),
    .m_data        (m_data),
    .m_err         (m_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .overrun       (overrun),
    .halted        (halted),
    .level         (level),
    .frame_count   (frame_count),
    .error_count   (error_count),
    .drop_count    (drop_count),
    .rx_timeout    (rx_timeout)
  );

  // behavioural model
  logic [DW:0] exp_q[$];
  bit md_halt, md_ovr;
  int md_frame, md_err, md_drop, md_idle;

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic model_edge();
    bit pop, push, run, was_nonempty;
    if (reset) begin
      exp_q.delete();
      md_halt = 0; md_ovr = 0;
      md_frame = 0; md_err = 0; md_drop = 0; md_idle = 0;
      return;
    end
    was_nonempty = (exp_q.size() != 0);
    pop  = was_nonempty && m_ready;
    run  = !md_halt || clear;
    push = 0;
    if (clear) begin
      md_halt = 0; md_ovr = 0; md_frame = 0; md_err = 0; md_drop = 0;
    end
    if (rx_valid) begin
      if (rx_error) md_err = sat(md_err);
      if (run && !(rx_error && drop_errored)) begin
        if (exp_q.size() < DEPTH || pop) push = 1;
        else begin md_ovr = 1; md_halt = 1; end
      end
      if (run && rx_error && halt_on_error) md_halt = 1;
      if (push) md_frame = sat(md_frame);
      else      md_drop  = sat(md_drop);
    end
    if (push || pop || clear) md_idle = 0;
    else if (was_nonempty && md_idle < TO) md_idle++;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back({rx_error, rx_data});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      check("level", 32'(level), 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        check("m_data", 32'(m_data), 32'(exp_q[0][DW-1:0]));
        check("m_err", 32'(m_err), 32'(exp_q[0][DW]));
      end
      check("overrun", 32'(overrun), 32'(md_ovr));
      check("halted", 32'(halted), 32'(md_halt));
      check("frame_count", 32'(frame_count), 32'(md_frame));
      check("error_count", 32'(error_count), 32'(md_err));
      check("drop_count", 32'(drop_count), 32'(md_drop));
`ifdef RX_TIMEOUT_EN
      check("rx_timeout", 32'(rx_timeout), 32'(md_idle == TO));
`else
      check("rx_timeout", 32'(rx_timeout), 32'(0));
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle_inputs();
    rx_valid = 0; rx_error = 0; rx_data = '0; clear = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic e);
    rx_valid = 1; rx_error = e; rx_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  initial begin
    reset = 1; m_ready = 0; halt_on_error = 0; drop_errored = 0;
    idle_inputs();
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    // single frame with consumer ready
    m_ready = 1;
    send(8'hA5, 0);
    check("single_valid", 32'(m_valid), 32'd1);
    check("single_data", 32'(m_data), 32'hA5);
    check("single_err", 32'(m_err), 32'd0);
    tick();
    check("single_level", 32'(level), 32'd0);
    check("single_frames", 32'(frame_count), 32'd1);

    // overrun on a ninth frame
    pulse_clear();
    m_ready = 0;
    for (int i = 0; i < 8; i++) send(DW'(i), 0);
    send(8'h08, 0);
    check("ovr_overrun", 32'(overrun), 32'd1);
    check("ovr_halted", 32'(halted), 32'd1);
    check("ovr_drops", 32'(drop_count), 32'd1);
    check("ovr_level", 32'(level), 32'd8);
    m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("ovr_drain", 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 0;
    pulse_clear();

    // full FIFO with simultaneous pop accepts the frame
    for (int i = 0; i < 8; i++) send(DW'(i), 0);
    m_ready = 1;
    send(8'h08, 0);
    check("fullpop_level", 32'(level), 32'd8);
    check("fullpop_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check("fullpop_drain", 32'(m_data), 32'(i));
      tick();
    end
    pulse_clear();

    // drop_errored filtering
    m_ready = 0; drop_errored = 1;
    send(8'h3C, 1);
    check("drop_err_count", 32'(error_count), 32'd1);
    check("drop_drop_count", 32'(drop_count), 32'd1);
    check("drop_m_valid", 32'(m_valid), 32'd0);
    drop_errored = 0;
    pulse_clear();

    // halt on error, then clear
    halt_on_error = 1;
    send(8'h55, 1);
    send(8'h66, 0);
    check("halt_level", 32'(level), 32'd1);
    check("halt_data", 32'(m_data), 32'h55);
    check("halt_err", 32'(m_err), 32'd1);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_drops", 32'(drop_count), 32'd1);
    pulse_clear();
    check("halt_clr_halted", 32'(halted), 32'd0);
    check("halt_clr_errors", 32'(error_count), 32'd0);
    send(8'h77, 0);
    check("halt_after_level", 32'(level), 32'd2);
    check("halt_after_frames", 32'(frame_count), 32'd1);
    halt_on_error = 0;
    m_ready = 1;
    tick(); tick();
    m_ready = 0;

`ifdef RX_TIMEOUT_EN
    pulse_clear();
    send(8'h11, 0);
    for (int i = 1; i < TO; i++) begin
      tick();
      check("tout_early", 32'(rx_timeout), 32'd0);
    end
    tick();
    check("tout_set", 32'(rx_timeout), 32'd1);
    m_ready = 1;
    tick();
    check("tout_clear", 32'(rx_timeout), 32'd0);
    m_ready = 0;
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int rdy_bias;
      if (c % 100 == 0) begin
        halt_on_error = ($urandom_range(0, 3) == 0);
        drop_errored  = ($urandom_range(0, 3) == 0);
      end
      rdy_bias = (c / 200) % 4;
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_error = ($urandom_range(0, 5) == 0);
      rx_data  = DW'($urandom);
      m_ready  = ($urandom_range(0, 3) < rdy_bias);
      clear    = ($urandom_range(0, 59) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_stream_ctrl.md
Name: rx_stream_ctrl

Overview:
- Sequences the UART receive datapath output into a buffered valid/ready byte stream for downstream logic.
- Captures each one-cycle received-frame strobe together with its parity-error flag and stores it in a small FIFO.
- Enforces overrun and error policy, and keeps frame, error and drop statistics.
- Sits between the receiver top level and the consumer, e.g. a register interface or command parser.

Parameters:
- INPUT_DATA_WIDTH, 8, width of a received data byte; matches the receiver.
- FIFO_DEPTH, 8, number of buffered frames; power of 2, at least 2.
- CNT_WIDTH, 16, width of the saturating statistics counters.
- TIMEOUT_CYCLES, 4096, idle cycles before rx_timeout asserts; used only with RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  INPUT_DATA_WIDTH  received byte from the receiver.
- rx_valid  input  1  one-cycle strobe; rx_data and rx_error are valid in this cycle.
- rx_error  input  1  parity error for the frame; sampled only when rx_valid=1.
- halt_on_error  input  1  when 1, a parity error moves the FSM to DISCARD.
- drop_errored  input  1  when 1, errored frames are counted but not stored.
- clear  input  1  one-cycle pulse; clears sticky flags and counters and returns the FSM to RUN.
- m_data  output  INPUT_DATA_WIDTH  head-of-FIFO byte.
- m_err  output  1  parity-error tag of the head entry.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts the head entry when m_valid & m_ready.
- overrun  output  1  sticky flag; a frame arrived while the FIFO was full.
- halted  output  1  FSM is in DISCARD.
- level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- frame_count  output  CNT_WIDTH  frames stored.
- error_count  output  CNT_WIDTH  frames received with rx_error=1, stored or not.
- drop_count  output  CNT_WIDTH  frames discarded for any reason.
- rx_timeout  output  1  idle timeout flag (see Optional Feature).

Behaviour:
- Reset values: every output is 0; FIFO is empty; FSM is in RUN; pointers are 0.
- FSM states: RUN, DISCARD.
  - RUN -> DISCARD on a rejected frame due to full FIFO, or on rx_valid & rx_error & halt_on_error.
  - DISCARD -> RUN only on clear.
- Push condition: rx_valid & state==RUN & !(rx_error & drop_errored) & (!full | pop_this_cycle).
  - The pushed entry is {rx_error, rx_data}.
  - A frame arriving while full with a simultaneous pop is accepted: no overrun, level unchanged.
- Pop condition: m_valid & m_ready.
- The FIFO is first-word fall-through:
  - m_data and m_err reflect the head entry combinationally from storage.
  - m_valid is registered (= level != 0).
  - A push in cycle N gives m_valid=1 in cycle N+1 when the FIFO was empty. Latency is 1 cycle.
- Pointers wrap modulo FIFO_DEPTH. level is updated as +1 (push only), -1 (pop only) or 0 (both, or neither).
- Drops: a frame with rx_valid=1 that is not pushed increments drop_count. Causes are DISCARD state, full FIFO, or drop_errored filtering.
  - A full-FIFO rejection also sets overrun.
  - An errored frame that triggers halt_on_error is still stored (unless drop_errored) before entering DISCARD.
- Counters saturate at all-ones and never wrap.
  - error_count increments on every rx_valid & rx_error, in either state.
  - frame_count increments on every push.
- clear: zeroes overrun, frame_count, error_count and drop_count, and forces RUN. FIFO contents and level are preserved.
  - If clear coincides with rx_valid, the frame is evaluated as RUN and counted after the clear; counters end at 0 or 1 accordingly.
- reset mid-frame or mid-pop: all state returns to reset values on the next edge. No partial entry survives.
- halted = (state==DISCARD). Popping continues in DISCARD so the consumer can drain.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs while level != 0 and neither push nor pop nor clear occurs.
  - rx_timeout asserts when the counter reaches TIMEOUT_CYCLES and holds until the next push, pop, clear or reset, which also zero the counter.
  - The counter stops at TIMEOUT_CYCLES.
- Without the macro: rx_timeout is tied to 0, no counter is built, and TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package/include rx_ctrl_pkg:
  - State encodings ST_RUN=1'b0 and ST_DISCARD=1'b1.
  - FIFO entry width localparam (INPUT_DATA_WIDTH+1).
  - Counter saturation helper.
- Sub-module rx_fifo: parameterised FWFT FIFO with push, pop, full, empty and level, holding the {err, data} entries.
- FSM, policy, counters and timeout stay in rx_stream_ctrl.

Test Plan:
- Single frame 0xA5 (rx_error=0), m_ready=1 -> m_valid=1 one cycle later with m_data=0xA5, m_err=0; then level returns to 0 and frame_count=1.
- 8 frames 0x00..0x07 with m_ready=0, then a 9th frame 0x08 -> overrun=1, halted=1, drop_count=1, level=8; draining yields 0x00..0x07 in order.
- FIFO full and a 9th frame arrives in the same cycle as a pop -> accepted, overrun=0, level=8, and 0x08 is the last entry out.
- drop_errored=1 and frame 0x3C with rx_error=1 -> not stored, error_count=1, drop_count=1, m_valid stays 0.
- halt_on_error=1 and an errored frame 0x55, then frame 0x66 -> 0x55 stored with m_err=1, 0x66 dropped, halted=1; clear pulse -> halted=0 and counters 0; next frame 0x77 stored.
- RX_TIMEOUT_EN with TIMEOUT_CYCLES=16: one frame stored and m_ready=0 -> rx_timeout=1 exactly 16 idle cycles after the push; a pop deasserts it on the next cycle.
